// File: rtl/add_rs_if.sv
// rtl/add_rs_if.sv - issue, CDB and dispatch signal bundle for the add/sub reservation station
interface add_rs_if #(
  parameter int DEPTH  = 3,
  parameter int DATA_W = 16,
  parameter int TAG_W  = 3,
  parameter int FUNC_W = 4
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic              iss_valid;
  logic              iss_ready;
  logic [FUNC_W-1:0] iss_func;
  logic [TAG_W-1:0]  iss_rob;
  logic              iss_v1;
  logic              iss_v2;
  logic [DATA_W-1:0] iss_d1;
  logic [DATA_W-1:0] iss_d2;
  logic [TAG_W-1:0]  iss_q1;
  logic [TAG_W-1:0]  iss_q2;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              flush;
  logic              disp_valid;
  logic              disp_ready;
  logic [FUNC_W-1:0] disp_func;
  logic [DATA_W-1:0] disp_a;
  logic [DATA_W-1:0] disp_b;
  logic [TAG_W-1:0]  disp_rob;
  logic [OCC_W-1:0]  occ;

  modport master (
    output iss_valid, iss_func, iss_rob, iss_v1, iss_v2, iss_d1, iss_d2, iss_q1, iss_q2,
    output cdb_valid, cdb_tag, cdb_data, flush, disp_ready,
    input  iss_ready, disp_valid, disp_func, disp_a, disp_b, disp_rob, occ
  );

  modport slave (
    input  iss_valid, iss_func, iss_rob, iss_v1, iss_v2, iss_d1, iss_d2, iss_q1, iss_q2,
    input  cdb_valid, cdb_tag, cdb_data, flush, disp_ready,
    output iss_ready, disp_valid, disp_func, disp_a, disp_b, disp_rob, occ
  );
endinterface

// File: rtl/add_rs_station.sv
// rtl/add_rs_station.sv - add/sub reservation station with CDB snooping and oldest-ready dispatch
module add_rs_station #(
  parameter int DEPTH  = 3,
  parameter int DATA_W = 16,
  parameter int TAG_W  = 3,
  parameter int FUNC_W = 4
) (
  input  logic   clk1,
  input  logic   rst_n,
  add_rs_if.slave bus
);
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0]  busy, v1, v2;
  logic [FUNC_W-1:0] func [DEPTH];
  logic [TAG_W-1:0]  rob  [DEPTH];
  logic [DATA_W-1:0] d1   [DEPTH];
  logic [DATA_W-1:0] d2   [DEPTH];
  logic [TAG_W-1:0]  q1   [DEPTH];
  logic [TAG_W-1:0]  q2   [DEPTH];
  logic [OCC_W-1:0]  age  [DEPTH];
  logic [OCC_W-1:0]  occ;

  logic              sel_found;
  logic [IDX_W-1:0]  sel_idx;
  logic [OCC_W-1:0]  sel_age;
  logic [FUNC_W-1:0] sel_func;
  logic [DATA_W-1:0] sel_a, sel_b;
  logic [TAG_W-1:0]  sel_rob;
  logic [IDX_W-1:0]  free_idx;
  logic              accept, fire;
  logic              hit1, hit2, new_v1, new_v2;
  logic [DATA_W-1:0] new_d1, new_d2;
  logic [OCC_W-1:0]  new_age;

  // Age 0 is the oldest; the smallest age among ready entries wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_age   = '0;
    sel_func  = '0;
    sel_a     = '0;
    sel_b     = '0;
    sel_rob   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (busy[i] && v1[i] && v2[i] && (!sel_found || age[i] < sel_age)) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
        sel_age   = age[i];
        sel_func  = func[i];
        sel_a     = d1[i];
        sel_b     = d2[i];
        sel_rob   = rob[i];
      end
    end
  end

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy[i]) free_idx = IDX_W'(i);
    end
  end

  assign bus.iss_ready  = (occ < OCC_W'(DEPTH));
  assign bus.disp_valid = sel_found;
  assign bus.disp_func  = sel_func;
  assign bus.disp_a     = sel_a;
  assign bus.disp_b     = sel_b;
  assign bus.disp_rob   = sel_rob;
  assign bus.occ        = occ;

  assign accept  = bus.iss_valid && bus.iss_ready;
  assign fire    = sel_found && bus.disp_ready;
  // Operands arriving on the CDB in the issue cycle are captured on the way in.
  assign hit1    = !bus.iss_v1 && bus.cdb_valid && (bus.iss_q1 == bus.cdb_tag);
  assign hit2    = !bus.iss_v2 && bus.cdb_valid && (bus.iss_q2 == bus.cdb_tag);
  assign new_v1  = bus.iss_v1 || hit1;
  assign new_v2  = bus.iss_v2 || hit2;
  assign new_d1  = hit1 ? bus.cdb_data : bus.iss_d1;
  assign new_d2  = hit2 ? bus.cdb_data : bus.iss_d2;
  assign new_age = occ - OCC_W'(fire);

  always_ff @(posedge clk1) begin
    if (!rst_n || bus.flush) begin
      busy <= '0;
      v1   <= '0;
      v2   <= '0;
      occ  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        func[i] <= '0;
        rob[i]  <= '0;
        d1[i]   <= '0;
        d2[i]   <= '0;
        q1[i]   <= '0;
        q2[i]   <= '0;
        age[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (busy[i] && bus.cdb_valid) begin
          if (!v1[i] && q1[i] == bus.cdb_tag) begin
            v1[i] <= 1'b1;
            d1[i] <= bus.cdb_data;
          end
          if (!v2[i] && q2[i] == bus.cdb_tag) begin
            v2[i] <= 1'b1;
            d2[i] <= bus.cdb_data;
          end
        end
        if (fire && sel_idx == IDX_W'(i)) begin
          busy[i] <= 1'b0;
        end else if (fire && busy[i] && age[i] > sel_age) begin
          age[i] <= age[i] - 1'b1;
        end
        if (accept && free_idx == IDX_W'(i)) begin
          busy[i] <= 1'b1;
          func[i] <= bus.iss_func;
          rob[i]  <= bus.iss_rob;
          v1[i]   <= new_v1;
          d1[i]   <= new_d1;
          q1[i]   <= bus.iss_q1;
          v2[i]   <= new_v2;
          d2[i]   <= new_d2;
          q2[i]   <= bus.iss_q2;
          age[i]  <= new_age;
        end
      end
      occ <= occ + OCC_W'(accept) - OCC_W'(fire);
    end
  end
endmodule

// File: tb/tb_add_rs_station.sv
// tb/tb_add_rs_station.sv - scoreboard bench for add_rs_station against an ordered-list model
module tb_add_rs_station;
  localparam int DEPTH = 3;

  logic clk1 = 1'b0;
  logic rst_n;
  always #5 clk1 = ~clk1;

  add_rs_if #(.DEPTH(DEPTH), .DATA_W(16), .TAG_W(3), .FUNC_W(4)) b ();

  add_rs_station #(.DEPTH(DEPTH), .DATA_W(16), .TAG_W(3), .FUNC_W(4)) dut (
    .clk1 (clk1),
    .rst_n(rst_n),
    .bus  (b)
  );

  typedef struct {
    logic [3:0]  func;
    logic [2:0]  rob;
    logic        v1;
    logic [15:0] d1;
    logic [2:0]  q1;
    logic        v2;
    logic [15:0] d2;
    logic [2:0]  q2;
  } ent_t;

  typedef struct {
    logic [3:0]  func;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  rob;
  } disp_t;

  ent_t  mq[$];   // station contents, oldest first
  disp_t sb[$];   // expected dispatches, in handshake order
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Called just after a negedge with inputs driven; returns at the next negedge.
  task automatic tick();
    int s;
    bit fire;
    ent_t e;
    #1;
    s = -1;
    for (int i = 0; i < mq.size(); i++)
      if (s < 0 && mq[i].v1 && mq[i].v2) s = i;
    check("disp_valid", b.disp_valid, s >= 0);
    check("occ", b.occ, mq.size());
    check("iss_ready", b.iss_ready, mq.size() < DEPTH);
    if (s < 0) check("disp_idle_zero", {b.disp_func, b.disp_a, b.disp_b, b.disp_rob}, 0);
    if (!rst_n || b.flush) begin
      mq.delete();
    end else begin
      fire = (s >= 0) && b.disp_ready;
      if (fire) sb.push_back('{mq[s].func, mq[s].d1, mq[s].d2, mq[s].rob});
      if (b.cdb_valid) begin
        for (int i = 0; i < mq.size(); i++) begin
          if (!(fire && i == s)) begin
            if (!mq[i].v1 && mq[i].q1 == b.cdb_tag) begin mq[i].v1 = 1'b1; mq[i].d1 = b.cdb_data; end
            if (!mq[i].v2 && mq[i].q2 == b.cdb_tag) begin mq[i].v2 = 1'b1; mq[i].d2 = b.cdb_data; end
          end
        end
      end
      if (b.iss_valid && mq.size() < DEPTH) begin
        e = '{b.iss_func, b.iss_rob, b.iss_v1, b.iss_d1, b.iss_q1, b.iss_v2, b.iss_d2, b.iss_q2};
        if (b.cdb_valid && !e.v1 && e.q1 == b.cdb_tag) begin e.v1 = 1'b1; e.d1 = b.cdb_data; end
        if (b.cdb_valid && !e.v2 && e.q2 == b.cdb_tag) begin e.v2 = 1'b1; e.d2 = b.cdb_data; end
        if (fire) mq.delete(s);
        mq.push_back(e);
      end else if (fire) begin
        mq.delete(s);
      end
    end
    @(negedge clk1);
  endtask

  task automatic idle();
    b.iss_valid = 1'b0;
    b.cdb_valid = 1'b0;
    b.flush     = 1'b0;
  endtask

  task automatic iss(input logic [3:0] f, input logic [2:0] r,
                     input logic v1, input logic [15:0] d1, input logic [2:0] q1,
                     input logic v2, input logic [15:0] d2, input logic [2:0] q2);
    b.iss_valid = 1'b1;
    b.iss_func  = f;  b.iss_rob = r;
    b.iss_v1    = v1; b.iss_d1  = d1; b.iss_q1 = q1;
    b.iss_v2    = v2; b.iss_d2  = d2; b.iss_q2 = q2;
  endtask

  task automatic cdb(input logic [2:0] t, input logic [15:0] d);
    b.cdb_valid = 1'b1;
    b.cdb_tag   = t;
    b.cdb_data  = d;
  endtask

  initial begin : monitor
    disp_t e;
    forever begin
      @(negedge clk1);
      #2;
      if (rst_n && !b.flush && b.disp_valid && b.disp_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_dispatch", {b.disp_rob, b.disp_a}, 0);
          if (b.disp_rob == 0 && b.disp_a == 0) begin
            miscompares++;
            $display("FAIL unexpected_dispatch: handshake with no expected entry at %0t", $time);
          end
        end else begin
          e = sb.pop_front();
          check("disp_func", b.disp_func, e.func);
          check("disp_a", b.disp_a, e.a);
          check("disp_b", b.disp_b, e.b);
          check("disp_rob", b.disp_rob, e.rob);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: run did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    idle();
    b.disp_ready = 1'b0;
    iss(4'h0, 3'd0, 1'b0, 16'h0, 3'd0, 1'b0, 16'h0, 3'd0);
    b.iss_valid = 1'b0;
    cdb(3'd0, 16'h0);
    b.cdb_valid = 1'b0;
    repeat (2) @(negedge clk1);
    tick();
    rst_n = 1'b1;

    // Ready add dispatches one cycle after issue.
    b.disp_ready = 1'b1;
    iss(4'b0000, 3'd2, 1'b1, 16'h0005, 3'd0, 1'b1, 16'h0003, 3'd0); tick();
    idle(); tick(); tick();

    // Sub waiting on tag 1, woken by the CDB.
    iss(4'b0001, 3'd4, 1'b0, 16'h0, 3'd1, 1'b1, 16'h0010, 3'd0); tick();
    idle(); tick();
    cdb(3'd1, 16'h0030); tick();
    idle(); tick(); tick();

    // Fill, overflow attempt, then drain in issue order.
    b.disp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      iss(4'b0000, 3'(i), 1'b1, 16'(16'h100 + i), 3'd0, 1'b1, 16'(i), 3'd0);
      tick();
    end
    idle(); tick();
    b.disp_ready = 1'b1;
    repeat (4) tick();

    // Issue/CDB race on operand 2.
    iss(4'b0000, 3'd6, 1'b1, 16'h0001, 3'd0, 1'b0, 16'h0, 3'd5);
    cdb(3'd5, 16'h00AA); tick();
    idle(); tick(); tick();

    // Younger entry wakes first and overtakes the older one.
    iss(4'b0001, 3'd1, 1'b0, 16'h0, 3'd3, 1'b1, 16'h0002, 3'd0); tick();
    iss(4'b0000, 3'd2, 1'b0, 16'h0, 3'd6, 1'b1, 16'h0004, 3'd0); tick();
    idle(); tick();
    cdb(3'd6, 16'h0066); tick();
    idle(); tick();
    cdb(3'd3, 16'h0033); tick();
    idle(); tick(); tick();

    // Flush and reset while entries are presented.
    for (int k = 0; k < 2; k++) begin
      b.disp_ready = 1'b0;
      iss(4'b0000, 3'd3, 1'b1, 16'h0011, 3'd0, 1'b1, 16'h0022, 3'd0); tick();
      iss(4'b0001, 3'd7, 1'b1, 16'h0033, 3'd0, 1'b1, 16'h0044, 3'd0); tick();
      idle(); tick();
      b.disp_ready = 1'b1;
      if (k == 0) b.flush = 1'b1; else rst_n = 1'b0;
      tick();
      b.flush = 1'b0; rst_n = 1'b1; b.disp_ready = 1'b0;
      tick();
    end

    // Randomized traffic.
    for (int n = 0; n < 800; n++) begin
      rst_n        = ($urandom_range(0, 149) != 0);
      b.flush      = ($urandom_range(0, 59) == 0);
      b.disp_ready = 1'($urandom_range(0, 2) != 0);
      iss(4'($urandom_range(0, 1)), 3'($urandom),
          1'($urandom_range(0, 2) == 0), 16'($urandom), 3'($urandom),
          1'($urandom_range(0, 2) == 0), 16'($urandom), 3'($urandom));
      b.iss_valid  = 1'($urandom_range(0, 1));
      cdb(3'($urandom), 16'($urandom));
      b.cdb_valid  = 1'($urandom_range(0, 1));
      tick();
    end
    rst_n = 1'b1;
    idle();
    b.disp_ready = 1'b1;
    repeat (4) tick();
    #3;
    check("scoreboard_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/add_rs_station.md
Name: add_rs_station

Overview:
- Reservation station for the add/sub functional unit. It sits directly downstream of the issue stage.
- Accepts one issued instruction per cycle: func, ROB tag, and two source operands. Each operand arrives either as a value or as a pending ROB tag.
- Snoops the common data bus (CDB) to fill pending operands.
- Dispatches the oldest fully-ready entry to the adder through a valid/ready handshake.
- Reports occupancy back to issue, which stalls when the station is full.

Parameters:
- DEPTH, 3, number of station entries (matches issue stage limit of 3 per unit)
- DATA_W, 16, operand/result width
- TAG_W, 3, ROB index width (8-entry ROB)
- FUNC_W, 4, opcode width

Ports:
- clk1  in  1  single clock; all state updates on posedge
- rst_n  in  1  synchronous active-low reset
- iss_valid  in  1  issue presents an instruction this cycle
- iss_ready  out  1  station can accept (occupancy < DEPTH)
- iss_func  in  FUNC_W  opcode (0000 add, 0001 sub)
- iss_rob  in  TAG_W  destination ROB index
- iss_v1, iss_v2  in  1 each  operand already valid
- iss_d1, iss_d2  in  DATA_W each  operand value when valid
- iss_q1, iss_q2  in  TAG_W each  producing ROB tag when not valid
- cdb_valid  in  1  broadcast strobe
- cdb_tag  in  TAG_W  broadcast ROB tag
- cdb_data  in  DATA_W  broadcast result
- flush  in  1  mispredict flush; empties station
- disp_valid  out  1  entry presented to adder
- disp_ready  in  1  adder accepts
- disp_func  out  FUNC_W  opcode of dispatched entry
- disp_a, disp_b  out  DATA_W each  operands
- disp_rob  out  TAG_W  ROB tag of dispatched entry
- occ  out  $clog2(DEPTH+1)  current number of busy entries

Behaviour:
- Reset (rst_n=0 at posedge): all entries not busy; occ=0; iss_ready=1; disp_valid=0; disp_* outputs=0. Reset mid-operation discards all entries without dispatch.
- Per-entry state: busy, func, rob, v1/d1/q1, v2/d2/q2, age.
- Issue accept: when iss_valid && iss_ready, write the lowest-index free entry at posedge.
  - The new entry's age is the youngest.
  - iss_ready is derived from registered occupancy only; a same-cycle dispatch does not free a slot for a same-cycle issue.
  - iss_valid with iss_ready=0 is ignored; no state change.
- CDB capture: each cycle cdb_valid=1, every busy entry operand with v=0 and q==cdb_tag sets v=1, d=cdb_data.
  - Issue/CDB race: if an issuing operand has v=0 and q==cdb_tag with cdb_valid=1 in the same cycle, it is stored as v=1, d=cdb_data.
- Ready: an entry is ready when busy && v1 && v2.
- Operand visibility: operands captured this cycle become ready next cycle. Minimum issue-to-disp_valid latency is 1 cycle when both operands are valid at issue.
- Select: disp_valid=1 iff at least one entry is ready. The oldest ready entry drives disp_*. Selection is combinational from registered state.
- Dispatch:
  - disp_valid && disp_ready at posedge frees the selected entry.
  - Ages of younger entries are compacted, so relative order is preserved.
  - disp_valid && !disp_ready: the same entry stays selected and disp_* stays stable, unless an older entry becomes ready. That is permitted, because the adder samples only on handshake.
- Simultaneous issue+dispatch: both take effect; occ unchanged.
- Simultaneous dispatch+CDB: the freed entry does not update; other entries capture normally.
- flush=1: at posedge all entries cleared, occ=0, same as reset. flush has priority over issue, dispatch and CDB in that cycle.
- occ: +1 on accept, -1 on dispatch handshake, saturating 0..DEPTH by construction.
- Tag equality is on full TAG_W bits; ROB wrap (7→0) needs no special handling.

Test Plan:
- Reset then issue add, rob=2, v1=v2=1, d1=0x0005, d2=0x0003, disp_ready=1 -> next cycle disp_valid=1, a=0x0005, b=0x0003, rob=2, func=0000; after handshake occ=0.
- Issue sub, rob=4, v1=0 q1=1, v2=1 d2=0x0010 -> disp_valid stays 0.
  - Then cdb_valid, tag=1, data=0x0030 -> disp_valid=1 next cycle, a=0x0030, b=0x0010.
- Fill 3 entries with disp_ready=0 -> iss_ready=0, occ=3; a 4th iss_valid is ignored.
  - Raise disp_ready -> entries dispatch in issue order, rob 0,1,2.
- Issue with q2=5 while cdb_valid, tag=5, data=0x00AA in the same cycle -> entry stored ready; dispatches with b=0x00AA.
- Two pending entries (older waiting on tag 3, younger on tag 6); broadcast tag 6 first -> younger dispatches. Then broadcast tag 3 -> older dispatches.
- Two busy entries, assert flush (or drop rst_n) while disp_valid=1 -> occ=0, disp_valid=0 next cycle, iss_ready=1; no handshake for the flushed entries.
